// File: rtl/sync_fifo.sv
// Show-ahead FIFO with occupancy count and synchronous flush.
// Serves as the fetch L0 buffer: replies in, decode pops, redirect clears.
module sync_fifo #(
  parameter int SLOTS = 2,
  parameter int WIDTH = 32,
  localparam int OW = $clog2(SLOTS > 1 ? SLOTS : 2) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear_i,
  input  logic             write_i,
  input  logic             read_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             error_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [OW-1:0]    ocup_o
);

  localparam int PW = OW - 1;
  localparam logic [PW-1:0] LAST = PW'(SLOTS - 1);

  logic [WIDTH-1:0] storage [SLOTS];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [OW-1:0]    count;
  logic             push;
  logic             pop;

  assign full_o  = (count == OW'(SLOTS));
  assign empty_o = (count == '0);
  assign ocup_o  = count;
  assign data_o  = storage[rd_ptr];

  assign push = write_i && !full_o && !clear_i;
  assign pop  = read_i && !empty_o && !clear_i;

  assign error_o = !clear_i &&
                   ((write_i && full_o) ||
                    (read_i && empty_o));

  // Explicit wrap so non-power-of-2 depths work.
  function automatic logic [PW-1:0] adv(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SLOTS; i++)
        storage[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        storage[wr_ptr] <= data_i;
        wr_ptr          <= adv(wr_ptr);
      end
      if (pop)
        rd_ptr <= adv(rd_ptr);
      unique case ({push, pop})
        2'b10:   count <= count + OW'(1);
        2'b01:   count <= count - OW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Random + directed bench for sync_fifo against a queue model.
// Drives two depths (2 and 3) with identical stimulus.
module tb_sync_fifo;

  logic        clk = 1'b0;
  logic        rst, clear, write, read;
  logic [31:0] din;

  logic [31:0] dout2, dout3;
  logic        err2, err3, full2, full3, empty2, empty3;
  logic [1:0]  ocup2;
  logic [2:0]  ocup3;

  int checks = 0;
  int failures = 0;

  logic [31:0] q2[$];
  logic [31:0] q3[$];
  bit          zero2 = 1'b1;
  bit          zero3 = 1'b1;

  always #5 clk = ~clk;

  sync_fifo #(.SLOTS(2), .WIDTH(32)) u_dut2 (
    .clk(clk), .rst(rst), .clear_i(clear),
    .write_i(write), .read_i(read), .data_i(din),
    .data_o(dout2), .error_o(err2), .full_o(full2),
    .empty_o(empty2), .ocup_o(ocup2)
  );

  sync_fifo #(.SLOTS(3), .WIDTH(32)) u_dut3 (
    .clk(clk), .rst(rst), .clear_i(clear),
    .write_i(write), .read_i(read), .data_i(din),
    .data_o(dout3), .error_o(err3), .full_o(full3),
    .empty_o(empty3), .ocup_o(ocup3)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Compare one DUT's pre-edge outputs with its model queue.
  task automatic check_one(
    input string       nm,
    input int          cap,
    input int          sz,
    input logic [31:0] head,
    input bit          zero_head,
    input logic [31:0] dout,
    input logic        err,
    input logic        full,
    input logic        empty,
    input logic [31:0] ocup
  );
    logic exp_err;
    exp_err = !clear &&
              ((write && sz == cap) || (read && sz == 0));
    chk({nm, ".ocup"},  ocup, 32'(sz));
    chk({nm, ".full"},  32'(full), 32'(sz == cap));
    chk({nm, ".empty"}, 32'(empty), 32'(sz == 0));
    chk({nm, ".error"}, 32'(err), 32'(exp_err));
    if (sz > 0)
      chk({nm, ".data"}, dout, head);
    else if (zero_head)
      chk({nm, ".data0"}, dout, 32'h0);
  endtask

  task automatic model(
    inout logic [31:0] q[$],
    inout bit          zero_head,
    input int          cap
  );
    bit pop_ok, push_ok;
    if (rst) begin
      q.delete();
      zero_head = 1'b1;
    end else if (clear) begin
      q.delete();
    end else begin
      pop_ok  = read && q.size() > 0;
      push_ok = write && q.size() < cap;
      if (pop_ok)
        void'(q.pop_front());
      if (push_ok) begin
        q.push_back(din);
        zero_head = 1'b0;
      end
    end
  endtask

  task automatic step(
    input logic        r,
    input logic        c,
    input logic        w,
    input logic        rd,
    input logic [31:0] d
  );
    @(negedge clk);
    rst = r; clear = c; write = w; read = rd; din = d;
    #1;
    check_one("s2", 2, q2.size(),
              q2.size() > 0 ? q2[0] : 32'h0, zero2,
              dout2, err2, full2, empty2, 32'(ocup2));
    check_one("s3", 3, q3.size(),
              q3.size() > 0 ? q3[0] : 32'h0, zero3,
              dout3, err3, full3, empty3, 32'(ocup3));
    model(q2, zero2, 2);
    model(q3, zero3, 3);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; write = 1'b0;
    read = 1'b0; din = '0;
    repeat (2) @(posedge clk);

    // Reset state.
    idle();
    chk("rst.data2", dout2, 32'h0);
    chk("rst.ocup2", 32'(ocup2), 32'h0);

    // Fill, drain, in order.
    step(0, 0, 1, 0, 32'hAAAA0001);
    step(0, 0, 1, 0, 32'hAAAA0002);
    idle();
    chk("fill.full2", 32'(full2), 32'h1);
    chk("fill.head2", dout2, 32'hAAAA0001);
    step(0, 0, 0, 1, 32'h0);
    idle();
    chk("pop.head2", dout2, 32'hAAAA0002);

    // Overflow on full, underflow on empty.
    step(0, 0, 1, 0, 32'hAAAA0003);
    step(0, 0, 1, 0, 32'h0000DEAD);
    step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);
    step(0, 0, 0, 1, 32'h0);

    // Empty push+pop: push only; then ocup 1 push+pop.
    step(0, 0, 1, 1, 32'h11110001);
    step(0, 0, 1, 1, 32'h11110002);
    idle();
    chk("pp.head2", dout2, 32'h11110002);

    // Ten push/pop pairs wrap pointers.
    for (int i = 0; i < 10; i++)
      step(0, 0, 1, 1, 32'h22220000 + 32'(i));
    step(0, 0, 1, 0, 32'h33330000);

    // Clear with write asserted.
    step(0, 1, 1, 0, 32'h44440000);
    idle();
    chk("clr.empty2", 32'(empty2), 32'h1);
    step(0, 0, 1, 0, 32'h00001234);
    idle();
    chk("clr.head2", dout2, 32'h00001234);

    // Reset mid-stream.
    step(0, 0, 1, 0, 32'h55550000);
    step(0, 0, 1, 0, 32'h55550001);
    step(1, 0, 1, 1, 32'h55550002);
    idle();
    chk("mid.data2", dout2, 32'h0);
    chk("mid.data3", dout3, 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 79) == 0,
           $urandom_range(0, 24) == 0,
           $urandom_range(0, 99) < 55,
           $urandom_range(0, 99) < 50,
           $urandom);
    end
    idle();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
